// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared opcodes, ALU encodings, FSM states and strobe bundle for the
//          hardwired control sequencer.
// Ports  : none (package).
package cpu_ctrl_pkg;

  localparam int OPC_W    = 5;
  localparam int ALU_OP_W = 4;

  // Opcodes taken from ir[31:27]
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd4;

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  // Instructions grouped by the shape of their execute sequence
  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_ADDI, CLS_BR,
    CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT, CLS_ILL
  } cls_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout;
    logic pcout, pcin, incpc;
    logic marin, mdrin, mdrout, memread, ramenable;
    logic yin, zin, zlowout, zhighout, cout, irin, conin;
    logic inport_out, outport_in, illegal;
  } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: combinational opcode -> instruction class and ALU operation.
// Ports  : opc_i (opcode field), cls_o (sequence class), alu_o (ALU select
//          for the register-register ALU class; ADD for everything else).
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]    opc_i,
  output cls_t                cls_o,
  output logic [ALU_OP_W-1:0] alu_o
);

  always_comb begin
    cls_o = CLS_ILL;
    alu_o = ALU_ADD;
    case (opc_i)
      OPC_LD:   cls_o = CLS_LD;
      OPC_LDI:  cls_o = CLS_LDI;
      OPC_ST:   cls_o = CLS_ST;
      OPC_ADD:  cls_o = CLS_ALU;
      OPC_SUB:  begin cls_o = CLS_ALU; alu_o = ALU_SUB; end
      OPC_AND:  begin cls_o = CLS_ALU; alu_o = ALU_AND; end
      OPC_OR:   begin cls_o = CLS_ALU; alu_o = ALU_OR;  end
      OPC_ADDI: cls_o = CLS_ADDI;
      OPC_BR:   cls_o = CLS_BR;
      OPC_IN:   cls_o = CLS_IN;
      OPC_OUT:  cls_o = CLS_OUT;
      OPC_NOP:  cls_o = CLS_NOP;
      OPC_HALT: cls_o = CLS_HALT;
      default:  cls_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose: hardwired Moore control unit stepping fetch T0..T2 and a
//          per-opcode execute sequence T3..T7, driving datapath strobes.
// Ports  : clock/clear (sync active-high), ir (opcode in [31:27]), CON
//          (branch flag), run, illegal, datapath strobes, alu_op.
//          Build macro CTRL_MEM_WAIT_EN adds mem_ready; memory steps stall
//          until it is high.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
`ifdef CTRL_MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  input  logic [31:0]         ir,
  input  logic                CON,
  output logic                run,
  output logic                illegal,
  output logic                Gra, Grb, Grc,
  output logic                Rin, Rout, BAout,
  output logic                PCout, PCin, IncPC,
  output logic                MARin, MDRin, MDRout, memRead,
  output logic                ramEnable,
  output logic                Yin, Zin, Zlowout, Zhighout, Cout, IRin, CONin,
  output logic                InPort_Out, OutPort_In,
  output logic [ALU_OP_W-1:0] alu_op
);

  state_t                state_q, state_d;
  cls_t                  cls;
  logic [ALU_OP_W-1:0]   alu_dec;
  logic                  mem_go;
  strobes_t              s;
  logic                  run_l;
  logic [ALU_OP_W-1:0]   alu_l;
  logic                  unused_ir;

  assign unused_ir = ^ir[26:0];

`ifdef CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  ctrl_decode u_decode (
    .opc_i (ir[31:27]),
    .cls_o (cls),
    .alu_o (alu_dec)
  );

  always_ff @(posedge clock) begin
    if (clear) state_q <= RST;
    else       state_q <= state_d;
  end

  // nop/halt are resolved on leaving T2, so the opcode must already be
  // visible on ir during T2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
      T1:  if (mem_go) state_d = T2;
      T2: begin
        case (cls)
          CLS_NOP:  state_d = T0;
          CLS_HALT: state_d = HALT;
          default:  state_d = T3;
        endcase
      end
      T3: begin
        case (cls)
          CLS_IN, CLS_OUT, CLS_ILL: state_d = T0;
          default:                  state_d = T4;
        endcase
      end
      T4: state_d = T5;
      T5: begin
        case (cls)
          CLS_LD, CLS_ST, CLS_BR: state_d = T6;
          default:                state_d = T0;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD:  if (mem_go) state_d = T7;
          CLS_ST:  state_d = T7;
          default: state_d = T0;
        endcase
      end
      T7:   if (cls != CLS_ST || mem_go) state_d = T0;
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    s     = '0;
    run_l = 1'b1;
    alu_l = ALU_NOP;
    case (state_q)
      T0: begin s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; end
      T1: begin s.memread = 1'b1; s.mdrin = 1'b1; end
      T2: begin s.mdrout = 1'b1; s.irin = 1'b1; end
      T3: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin s.grb = 1'b1; s.baout = 1'b1; s.yin = 1'b1; end
          CLS_ALU, CLS_ADDI:       begin s.grb = 1'b1; s.rout = 1'b1; s.yin = 1'b1; end
          CLS_BR:  begin s.gra = 1'b1; s.rout = 1'b1; s.conin = 1'b1; end
          CLS_IN:  begin s.gra = 1'b1; s.rin = 1'b1; s.inport_out = 1'b1; end
          CLS_OUT: begin s.gra = 1'b1; s.rout = 1'b1; s.outport_in = 1'b1; end
          CLS_ILL: s.illegal = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin s.cout = 1'b1; s.zin = 1'b1; alu_l = ALU_ADD; end
          CLS_ALU: begin s.grc = 1'b1; s.rout = 1'b1; s.zin = 1'b1; alu_l = alu_dec; end
          CLS_BR:  begin s.pcout = 1'b1; s.yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_LDI, CLS_ALU, CLS_ADDI: begin s.zlowout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          CLS_LD, CLS_ST: begin s.zlowout = 1'b1; s.marin = 1'b1; end
          CLS_BR:  begin s.cout = 1'b1; s.zin = 1'b1; alu_l = ALU_ADD; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD:  begin s.memread = 1'b1; s.mdrin = 1'b1; end
          CLS_ST:  begin s.gra = 1'b1; s.rout = 1'b1; s.mdrin = 1'b1; end
          // Branch taken only when the condition flag is set during T6
          CLS_BR:  begin s.zlowout = CON; s.pcin = CON; end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CLS_LD:  begin s.mdrout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
          CLS_ST:  s.ramenable = 1'b1;
          default: ;
        endcase
      end
      HALT:    run_l = 1'b0;
      default: ;
    endcase
  end

  assign run        = run_l;
  assign alu_op     = alu_l;
  assign illegal    = s.illegal;
  assign Gra        = s.gra;
  assign Grb        = s.grb;
  assign Grc        = s.grc;
  assign Rin        = s.rin;
  assign Rout       = s.rout;
  assign BAout      = s.baout;
  assign PCout      = s.pcout;
  assign PCin       = s.pcin;
  assign IncPC      = s.incpc;
  assign MARin      = s.marin;
  assign MDRin      = s.mdrin;
  assign MDRout     = s.mdrout;
  assign memRead    = s.memread;
  assign ramEnable  = s.ramenable;
  assign Yin        = s.yin;
  assign Zin        = s.zin;
  assign Zlowout    = s.zlowout;
  assign Zhighout   = s.zhighout;
  assign Cout       = s.cout;
  assign IRin       = s.irin;
  assign CONin      = s.conin;
  assign InPort_Out = s.inport_out;
  assign OutPort_In = s.outport_in;

endmodule
